led_trail_pwm: RTL and testbench



---
 rtl/led_pkg.sv | 16 +
 rtl/led_pwm_channel.sv | 42 ++++
 rtl/led_trail_pwm.sv | 90 +++++++++
 tb/tb_led_trail_pwm.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// Shared defaults, brightness ceiling helper and sequencing states for the LED trail PWM block.
package led_pkg;

  localparam int N_LEDS_DEF = 4;
  localparam int BW_DEF     = 4;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } state_e;

  function automatic int max_of(input int bw);
    return (1 << bw) - 1;
  endfunction

endpackage

// File: rtl/led_pwm_channel.sv
// One LED channel: brightness register with afterglow decay and a registered PWM comparator.
module led_pwm_channel
  import led_pkg::*;
#(
  parameter int BW          = BW_DEF,
  parameter int DECAY_SHIFT = 1
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          apply,
  input  logic          src,
  input  logic [BW-1:0] pwm_cnt,
  output logic          led
);

  localparam logic [BW-1:0] MAX = BW'(max_of(BW));

  logic [BW-1:0] bright_q, bright_d;
  logic          led_q, led_d;

  // Lit LEDs jump to full scale; unlit ones fade by a logical shift toward zero.
  always_comb begin
    bright_d = bright_q;
    if (apply) begin
      bright_d = src ? MAX : (bright_q >> DECAY_SHIFT);
    end
    led_d = (pwm_cnt < bright_q);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bright_q <= '0;
      led_q    <= 1'b0;
    end else begin
      bright_q <= bright_d;
      led_q    <= led_d;
    end
  end

  assign led = led_q;

endmodule

// File: rtl/led_trail_pwm.sv
// Converts sequencer steps into per-LED afterglow brightness, applied only at PWM period boundaries.
module led_trail_pwm
  import led_pkg::*;
#(
  parameter int N_LEDS      = N_LEDS_DEF,
  parameter int BW          = BW_DEF,
  parameter int DECAY_SHIFT = 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              step,
  input  logic [N_LEDS-1:0] light_in,
  output logic [N_LEDS-1:0] led_out,
  output logic              frame_start,
  output logic              update_pending
);

  localparam logic [BW-1:0] MAX = BW'(max_of(BW));

  logic [BW-1:0]     pwm_cnt_q, pwm_cnt_d;
  state_e            state_q, state_d;
  logic [N_LEDS-1:0] snap_q, snap_d;
  logic              frame_start_q, frame_start_d;
  logic              apply_cycle;
  logic              apply;
  logic [N_LEDS-1:0] src_vec;

  assign apply_cycle = (pwm_cnt_q == (MAX - 1'b1));

  always_comb begin
    pwm_cnt_d     = apply_cycle ? '0 : (pwm_cnt_q + 1'b1);
    frame_start_d = (pwm_cnt_q == '0);
  end

  // A step landing in the apply cycle is used directly; otherwise the latest snapshot wins.
  always_comb begin
    state_d = state_q;
    snap_d  = snap_q;
    case (state_q)
      IDLE: begin
        if (step && !apply_cycle) begin
          snap_d  = light_in;
          state_d = PENDING;
        end
      end
      PENDING: begin
        if (apply_cycle) begin
          state_d = IDLE;
        end else if (step) begin
          snap_d = light_in;
        end
      end
      default: state_d = IDLE;
    endcase
    apply   = apply_cycle && (step || (state_q == PENDING));
    src_vec = step ? light_in : snap_q;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pwm_cnt_q     <= '0;
      state_q       <= IDLE;
      snap_q        <= '0;
      frame_start_q <= 1'b0;
    end else begin
      pwm_cnt_q     <= pwm_cnt_d;
      state_q       <= state_d;
      snap_q        <= snap_d;
      frame_start_q <= frame_start_d;
    end
  end

  for (genvar i = 0; i < N_LEDS; i++) begin : g_chan
    led_pwm_channel #(
      .BW          (BW),
      .DECAY_SHIFT (DECAY_SHIFT)
    ) u_chan (
      .clock   (clock),
      .reset_n (reset_n),
      .apply   (apply),
      .src     (src_vec[i]),
      .pwm_cnt (pwm_cnt_q),
      .led     (led_out[i])
    );
  end

  assign frame_start    = frame_start_q;
  assign update_pending = (state_q == PENDING);

endmodule

// File: tb/tb_led_trail_pwm.sv
// Directed bench for led_trail_pwm: per-period on-counts, deferred updates and async reset.
module tb_led_trail_pwm;

  logic       clock;
  logic       reset_n;
  logic       step;
  logic [3:0] light_in;
  logic [3:0] led_out;
  logic       frame_start;
  logic       update_pending;

  int checks   = 0;
  int failures = 0;
  int cnt_m;

  led_trail_pwm dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .step           (step),
    .light_in       (light_in),
    .led_out        (led_out),
    .frame_start    (frame_start),
    .update_pending (update_pending)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Expected pwm_cnt seen by the DUT at the next rising edge.
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) cnt_m <= 0;
    else          cnt_m <= (cnt_m == 14) ? 0 : cnt_m + 1;
  end

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic do_step(input int c, input logic [3:0] pat);
    int guard = 0;
    do begin
      @(negedge clock);
      guard++;
    end while (cnt_m != c && guard < 40);
    step     = 1'b1;
    light_in = pat;
    @(negedge clock);
    step     = 1'b0;
    light_in = 4'b0000;
  endtask

  task automatic wait_cnt(input int c);
    int guard = 0;
    do begin
      @(negedge clock);
      guard++;
    end while (cnt_m != c && guard < 40);
  endtask

  task automatic measure_period(input string tag, input int e0, input int e1,
                                input int e2, input int e3);
    int on [4];
    int fs_hits = 0;
    int fs_first = 0;
    int pend_hits = 0;
    int guard = 0;
    while (cnt_m != 0 && guard < 40) begin
      @(negedge clock);
      guard++;
    end
    for (int k = 0; k < 4; k++) on[k] = 0;
    for (int s = 0; s < 15; s++) begin
      @(posedge clock);
      #1;
      for (int k = 0; k < 4; k++) if (led_out[k]) on[k]++;
      if (frame_start) fs_hits++;
      if (s == 0) fs_first = int'(frame_start);
      if (update_pending) pend_hits++;
    end
    chk({tag, "_led0"}, on[0], e0);
    chk({tag, "_led1"}, on[1], e1);
    chk({tag, "_led2"}, on[2], e2);
    chk({tag, "_led3"}, on[3], e3);
    chk({tag, "_frame_hits"}, fs_hits, 1);
    chk({tag, "_frame_first"}, fs_first, 1);
    chk({tag, "_pending"}, pend_hits, 0);
  endtask

  task automatic pulse_reset();
    @(negedge clock);
    reset_n = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n  = 1'b0;
    step     = 1'b0;
    light_in = 4'b1111;

    // Test 1: reset held with step toggling, then idle periods.
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      step = ~step;
    end
    @(posedge clock);
    #1;
    chk("rst_led", int'(led_out), 0);
    chk("rst_frame", int'(frame_start), 0);
    chk("rst_pending", int'(update_pending), 0);
    @(negedge clock);
    step     = 1'b0;
    light_in = 4'b0000;
    reset_n  = 1'b1;
    measure_period("idle_p1", 0, 0, 0, 0);
    measure_period("idle_p2", 0, 0, 0, 0);
    measure_period("idle_p3", 0, 0, 0, 0);

    // Test 2: single step mid-period is deferred to the boundary.
    do_step(3, 4'b0001);
    chk("t2_pending_after_step", int'(update_pending), 1);
    wait_cnt(14);
    chk("t2_pending_apply_cycle", int'(update_pending), 1);
    measure_period("t2", 15, 0, 0, 0);

    // Test 3: walking steps build the decaying trail.
    do_step(3, 4'b0001);
    measure_period("t3a", 15, 0, 0, 0);
    do_step(3, 4'b0010);
    measure_period("t3b", 7, 15, 0, 0);
    do_step(3, 4'b0100);
    measure_period("t3c", 3, 7, 15, 0);
    do_step(3, 4'b1000);
    measure_period("t3d", 1, 3, 7, 15);

    // Test 4: two steps in one period collapse into one update.
    pulse_reset();
    do_step(3, 4'b0001);
    measure_period("t4_pre", 15, 0, 0, 0);
    do_step(2, 4'b0001);
    chk("t4_pending_first", int'(update_pending), 1);
    do_step(9, 4'b0010);
    chk("t4_pending_second", int'(update_pending), 1);
    measure_period("t4", 7, 15, 0, 0);

    // Test 5: step in the apply cycle applies at once; nothing pends.
    wait_cnt(13);
    chk("t5_pending_before", int'(update_pending), 0);
    do_step(14, 4'b0100);
    chk("t5_pending_after", int'(update_pending), 0);
    measure_period("t5", 3, 7, 15, 0);
    measure_period("t5_hold", 3, 7, 15, 0);

    // Test 6: async reset while pending with LEDs lit.
    do_step(3, 4'b1000);
    chk("t6_pending", int'(update_pending), 1);
    chk("t6_led_before", int'(led_out), 4'b0110);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t6_led_async", int'(led_out), 0);
    chk("t6_pending_async", int'(update_pending), 0);
    chk("t6_frame_async", int'(frame_start), 0);
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    measure_period("t6_after", 0, 0, 0, 0);
    measure_period("t6_after2", 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=0 exp=1");
    $fatal(1, "timeout");
  end

endmodule
